// File: rtl/instruction_fetch_unit.sv
// IF-stage fetch unit: local instruction store, architectural PC and a FETCH/IMM FSM
// that merges two-word LDM instructions (opcode + immediate) into one output beat.
`timescale 1ns/1ps
module instruction_fetch_unit #(
  parameter int                WORD_W   = 16,
  parameter int                PC_W     = 32,
  parameter int                ADDR_W   = 5,
  parameter int                OPC_W    = 5,
  parameter logic [OPC_W-1:0]  LDM_OPC  = 5'h1F,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WORD_W-1:0] prog_data,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] immediate,
  output logic              has_imm,
  output logic [PC_W-1:0]   instr_pc,
  output logic [PC_W-1:0]   pc
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    FETCH = 1'b0,
    IMM   = 1'b1
  } state_t;

  logic [WORD_W-1:0] mem [DEPTH];

  state_t            state, state_next;
  logic [WORD_W-1:0] hold_word, hold_word_next;
  logic [PC_W-1:0]   hold_pc, hold_pc_next;
  logic [PC_W-1:0]   pc_next;
  logic              instr_valid_next;
  logic [WORD_W-1:0] instruction_next;
  logic [WORD_W-1:0] immediate_next;
  logic              has_imm_next;
  logic [PC_W-1:0]   instr_pc_next;

  logic [WORD_W-1:0] read_word;
  logic              read_is_ldm;

  // Asynchronous read feeding registered outputs gives read-before-write on a same-address load.
  assign read_word   = mem[pc[ADDR_W-1:0]];
  assign read_is_ldm = (read_word[WORD_W-1 -: OPC_W] == LDM_OPC);

  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    state_next       = state;
    hold_word_next   = hold_word;
    hold_pc_next     = hold_pc;
    pc_next          = pc;
    instr_valid_next = instr_valid;
    instruction_next = instruction;
    immediate_next   = immediate;
    has_imm_next     = has_imm;
    instr_pc_next    = instr_pc;

    if (redirect_valid) begin
      // A redirect wins over stall and throws away any half-assembled LDM.
      pc_next          = redirect_pc;
      state_next       = FETCH;
      instr_valid_next = 1'b0;
      has_imm_next     = 1'b0;
      hold_word_next   = '0;
      hold_pc_next     = '0;
    end else if (!stall) begin
      unique case (state)
        FETCH: begin
          pc_next = pc + PC_W'(1);
          if (read_is_ldm) begin
            hold_word_next   = read_word;
            hold_pc_next     = pc;
            instr_valid_next = 1'b0;
            state_next       = IMM;
          end else begin
            instruction_next = read_word;
            immediate_next   = '0;
            has_imm_next     = 1'b0;
            instr_pc_next    = pc;
            instr_valid_next = 1'b1;
          end
        end
        IMM: begin
          instruction_next = hold_word;
          immediate_next   = read_word;
          has_imm_next     = 1'b1;
          instr_pc_next    = hold_pc;
          instr_valid_next = 1'b1;
          pc_next          = pc + PC_W'(1);
          state_next       = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      hold_word   <= '0;
      hold_pc     <= '0;
      instr_valid <= 1'b0;
      instruction <= '0;
      immediate   <= '0;
      has_imm     <= 1'b0;
      instr_pc    <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      hold_word   <= hold_word_next;
      hold_pc     <= hold_pc_next;
      instr_valid <= instr_valid_next;
      instruction <= instruction_next;
      immediate   <= immediate_next;
      has_imm     <= has_imm_next;
      instr_pc    <= instr_pc_next;
    end
  end

endmodule
